// File: rtl/c3aibadapt_avmm_dcg_pkg.sv
// Shared encodings for the AVMM dynamic-clock-gating scheduler: FSM states,
// testbus field layout and the recommended wake/idle configuration values.
package c3aibadapt_avmm_dcg_pkg;

    localparam logic [2:0] ST_GATED     = 3'd0;
    localparam logic [2:0] ST_UNGATING  = 3'd1;
    localparam logic [2:0] ST_ACTIVE    = 3'd2;
    localparam logic [2:0] ST_IDLE_WAIT = 3'd3;
    localparam logic [2:0] ST_GATING    = 3'd4;

    localparam int TB_STATE_LSB  = 0;
    localparam int TB_DCG_EN_BIT = 3;
    localparam int TB_CNT_LSB    = 4;

    localparam logic [3:0] DEF_WAKE_CNT = 4'hF;
    localparam logic [7:0] DEF_IDLE_CNT = 8'h20;

    // The downstream gated clock is running in these states.
    function automatic logic clk_running(input logic [2:0] st);
        return (st == ST_UNGATING) || (st == ST_ACTIVE) || (st == ST_IDLE_WAIT);
    endfunction

endpackage

// File: rtl/c3aibadapt_avmm_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after ptr+1,
// wrapping modulo NREQ. Pointer storage and grant hold live in the caller.
module c3aibadapt_avmm_rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    always_comb begin
        logic [PW-1:0] cand;
        cand    = '0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        if (en_i) begin
            // Walk from farthest to nearest so the nearest hit is the last write.
            for (int k = NREQ; k >= 1; k--) begin
                cand = PW'((int'(ptr_i) + k) % NREQ);
                if (req_i[cand]) begin
                    valid_o     = 1'b1;
                    idx_o       = cand;
                    gnt_o       = '0;
                    gnt_o[cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/c3aibadapt_avmm_dcg_sched.sv
// AVMM requester arbiter plus DCG ungate/gate sequencer: wakes the gated clock
// before granting and gates it again after a programmable idle period.
module c3aibadapt_avmm_dcg_sched
    import c3aibadapt_avmm_dcg_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r_dcg_en_i,
    input  logic [3:0]      r_wake_cnt_i,
    input  logic [IW-1:0]   r_idle_cnt_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            dcg_ungate_o,
    output logic            dcg_gate_o,
    output logic            clk_active_o,
    output logic [7:0]      dcg_sched_testbus_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (IW > 4) ? IW : 4;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            ungate_q, ungate_d;
    logic            gate_q, gate_d;

    logic            any_req;
    logic            owner_req;
    logic            arb_en;
    logic            arb_valid;
    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;

    assign any_req   = |req_i;
    assign owner_req = |(gnt_q & req_i);
    assign arb_en    = (state_q == ST_ACTIVE) && (gnt_q == '0);

    c3aibadapt_avmm_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        ungate_d = 1'b0;
        gate_d   = 1'b0;
        case (state_q)
            ST_GATED: begin
                if (any_req) begin
                    if (r_dcg_en_i) begin
                        state_d  = ST_UNGATING;
                        cnt_d    = CW'(r_wake_cnt_i);
                        ungate_d = 1'b1;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_UNGATING: begin
                if (!r_dcg_en_i) begin
                    state_d = any_req ? ST_ACTIVE : ST_GATED;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACTIVE: begin
                // Releasing a grant never re-arbitrates in the same cycle, leaving a bubble.
                if (gnt_q != '0) begin
                    if (!owner_req) begin
                        gnt_d = '0;
                        if (!any_req) begin
                            if (r_dcg_en_i) begin
                                state_d = ST_IDLE_WAIT;
                                cnt_d   = CW'(r_idle_cnt_i);
                            end else begin
                                state_d = ST_GATED;
                            end
                        end
                    end
                end else if (arb_valid) begin
                    gnt_d = arb_gnt;
                    ptr_d = arb_idx;
                end else if (r_dcg_en_i) begin
                    state_d = ST_IDLE_WAIT;
                    cnt_d   = CW'(r_idle_cnt_i);
                end else begin
                    state_d = ST_GATED;
                end
            end
            ST_IDLE_WAIT: begin
                if (!r_dcg_en_i) begin
                    state_d = any_req ? ST_ACTIVE : ST_GATED;
                end else if (any_req) begin
                    state_d = ST_ACTIVE;
                end else if (cnt_q == '0) begin
                    state_d = ST_GATING;
                    gate_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GATING: begin
                state_d = ST_GATED;
            end
            default: begin
                state_d = ST_GATED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_GATED;
            cnt_q    <= '0;
            gnt_q    <= '0;
            ptr_q    <= '0;
            ungate_q <= 1'b0;
            gate_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            ungate_q <= ungate_d;
            gate_q   <= gate_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign dcg_ungate_o = ungate_q;
    assign dcg_gate_o   = gate_q;
    assign clk_active_o = clk_running(state_q);

    always_comb begin
        dcg_sched_testbus_o                        = '0;
        dcg_sched_testbus_o[TB_STATE_LSB +: 3]     = state_q;
        dcg_sched_testbus_o[TB_DCG_EN_BIT]         = r_dcg_en_i;
        dcg_sched_testbus_o[TB_CNT_LSB +: 4]       = cnt_q[3:0];
    end

endmodule

// File: tb/tb_c3aibadapt_avmm_dcg_sched.sv
// Self-checking bench for the AVMM DCG scheduler: wake/idle sequencing,
// round-robin order, idle re-arm, DCG-disabled mode and async reset.
module tb_c3aibadapt_avmm_dcg_sched;

    localparam int NREQ = 4;
    localparam int IW   = 8;
    localparam logic [2:0] S_GATED     = 3'd0;
    localparam logic [2:0] S_UNGATING  = 3'd1;
    localparam logic [2:0] S_ACTIVE    = 3'd2;
    localparam logic [2:0] S_IDLE_WAIT = 3'd3;
    localparam logic [2:0] S_GATING    = 3'd4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            r_dcg_en = 1'b1;
    logic [3:0]      r_wake_cnt = 4'd3;
    logic [IW-1:0]   r_idle_cnt = 8'd4;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic            dcg_ungate;
    logic            dcg_gate;
    logic            clk_active;
    logic [7:0]      tbus;

    int n_vec = 0;
    int n_miss = 0;
    int n_ungate = 0;
    int n_gate = 0;
    logic [NREQ-1:0] exp_q[$];
    logic [NREQ-1:0] prev_gnt = '0;

    c3aibadapt_avmm_dcg_sched #(.NREQ(NREQ), .IW(IW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .r_dcg_en_i          (r_dcg_en),
        .r_wake_cnt_i        (r_wake_cnt),
        .r_idle_cnt_i        (r_idle_cnt),
        .req_i               (req),
        .gnt_o               (gnt),
        .dcg_ungate_o        (dcg_ungate),
        .dcg_gate_o          (dcg_gate),
        .clk_active_o        (clk_active),
        .dcg_sched_testbus_o (tbus)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // per-cycle invariants and grant scoreboard
    always @(negedge clk) begin
        if (dcg_ungate) n_ungate++;
        if (dcg_gate) n_gate++;
        n_vec++;
        if ((dcg_ungate && dcg_gate) || !$onehot0(gnt) ||
            (gnt != '0 && tbus[2:0] != S_ACTIVE) ||
            (gnt != '0 && prev_gnt != '0 && gnt != prev_gnt)) begin
            n_miss++;
            $display("FAIL invariant: gnt=%b prev=%b ungate=%b gate=%b state=%0d",
                     gnt, prev_gnt, dcg_ungate, dcg_gate, tbus[2:0]);
        end
        if (gnt != '0 && gnt != prev_gnt) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL grant_order: got %b, expected no grant", gnt);
            end else begin
                logic [NREQ-1:0] e;
                e = exp_q.pop_front();
                if (gnt !== e) begin
                    n_miss++;
                    $display("FAIL grant_order: got %b, expected %b", gnt, e);
                end
            end
        end
        prev_gnt = gnt;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (gnt !== '0 || dcg_ungate !== 1'b0 || dcg_gate !== 1'b0 || clk_active !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_outputs: gnt=%b ungate=%b gate=%b act=%b, expected all 0",
                     gnt, dcg_ungate, dcg_gate, clk_active);
        end
        n_vec++;
        if (tbus !== 8'h08) begin
            n_miss++;
            $display("FAIL reset_testbus: got %h expected 08", tbus);
        end
    endtask

    task automatic test_wake();
        int u0;
        u0 = n_ungate;
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        step();
        n_vec++;
        if (dcg_ungate !== 1'b1 || tbus[2:0] !== S_UNGATING || tbus[7:4] !== 4'd3) begin
            n_miss++;
            $display("FAIL wake_edge0: ungate=%b state=%0d cnt=%0d, expected 1/1/3",
                     dcg_ungate, tbus[2:0], tbus[7:4]);
        end
        step();
        n_vec++;
        if (dcg_ungate !== 1'b0 || clk_active !== 1'b1 || tbus[7:4] !== 4'd2) begin
            n_miss++;
            $display("FAIL wake_edge1: ungate=%b act=%b cnt=%0d, expected 0/1/2",
                     dcg_ungate, clk_active, tbus[7:4]);
        end
        repeat (3) step();
        n_vec++;
        if (tbus[2:0] !== S_ACTIVE || gnt !== '0) begin
            n_miss++;
            $display("FAIL wake_edge4: state=%0d gnt=%b, expected 2/0000", tbus[2:0], gnt);
        end
        step();
        n_vec++;
        if (gnt !== 4'b0100) begin
            n_miss++;
            $display("FAIL wake_grant: got %b expected 0100", gnt);
        end
        n_vec++;
        if (n_ungate - u0 !== 1) begin
            n_miss++;
            $display("FAIL wake_ungate_count: got %0d expected 1", n_ungate - u0);
        end
    endtask

    task automatic test_idle();
        int g0;
        req = '0;
        step();
        n_vec++;
        if (gnt !== '0 || tbus[2:0] !== S_IDLE_WAIT || tbus[7:4] !== 4'd4) begin
            n_miss++;
            $display("FAIL idle_enter: gnt=%b state=%0d cnt=%0d, expected 0000/3/4",
                     gnt, tbus[2:0], tbus[7:4]);
        end
        g0 = n_gate;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_vec++;
            if (dcg_gate !== 1'b0) begin
                n_miss++;
                $display("FAIL idle_early_gate: k+%0d gate=%b expected 0", i, dcg_gate);
            end
        end
        step();
        n_vec++;
        if (dcg_gate !== 1'b1 || tbus[2:0] !== S_GATING) begin
            n_miss++;
            $display("FAIL idle_gate_pulse: gate=%b state=%0d, expected 1/4", dcg_gate, tbus[2:0]);
        end
        step();
        n_vec++;
        if (dcg_gate !== 1'b0 || tbus[2:0] !== S_GATED || clk_active !== 1'b0 || n_gate - g0 !== 1) begin
            n_miss++;
            $display("FAIL idle_gated: gate=%b state=%0d act=%b pulses=%0d, expected 0/0/0/1",
                     dcg_gate, tbus[2:0], clk_active, n_gate - g0);
        end
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] order [3];
        order[0] = 4'b0010;
        order[1] = 4'b1000;
        order[2] = 4'b0001;
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(order[i]);
        req = 4'b1011;
        for (int t = 0; t < 20 && gnt === '0; t++) step();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (gnt !== order[i]) begin
                n_miss++;
                $display("FAIL rr_grant%0d: got %b expected %b", i, gnt, order[i]);
            end
            step();
            req = req & ~order[i];
            step();
            n_vec++;
            if (gnt !== '0) begin
                n_miss++;
                $display("FAIL rr_bubble%0d: got %b expected 0000", i, gnt);
            end
            if (i < 2) step();
        end
        n_vec++;
        if (tbus[2:0] !== S_IDLE_WAIT || tbus[7:4] !== 4'd4) begin
            n_miss++;
            $display("FAIL rr_to_idle: state=%0d cnt=%0d expected 3/4", tbus[2:0], tbus[7:4]);
        end
    endtask

    task automatic test_idle_rearm();
        int u0, g0;
        repeat (2) step();
        n_vec++;
        if (tbus[2:0] !== S_IDLE_WAIT || tbus[7:4] !== 4'd2) begin
            n_miss++;
            $display("FAIL rearm_cnt: state=%0d cnt=%0d expected 3/2", tbus[2:0], tbus[7:4]);
        end
        u0 = n_ungate;
        g0 = n_gate;
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        step();
        n_vec++;
        if (tbus[2:0] !== S_ACTIVE || gnt !== '0) begin
            n_miss++;
            $display("FAIL rearm_active: state=%0d gnt=%b expected 2/0000", tbus[2:0], gnt);
        end
        step();
        n_vec++;
        if (gnt !== 4'b0001 || n_ungate != u0 || n_gate != g0) begin
            n_miss++;
            $display("FAIL rearm_grant: gnt=%b ungates=%0d gates=%0d expected 0001/0/0",
                     gnt, n_ungate - u0, n_gate - g0);
        end
        req = '0;
        repeat (8) step();
        n_vec++;
        if (tbus[2:0] !== S_GATED) begin
            n_miss++;
            $display("FAIL rearm_regate: state=%0d expected 0", tbus[2:0]);
        end
    endtask

    task automatic test_dcg_off();
        int u0, g0, ptr, idx;
        logic [NREQ-1:0] m, e;
        r_dcg_en = 1'b0;
        do_reset();
        u0 = n_ungate;
        g0 = n_gate;
        step();
        req = 4'b1000;
        exp_q.push_back(4'b1000);
        step();
        n_vec++;
        if (tbus[2:0] !== S_ACTIVE || gnt !== '0) begin
            n_miss++;
            $display("FAIL off_edge1: state=%0d gnt=%b expected 2/0000", tbus[2:0], gnt);
        end
        step();
        n_vec++;
        if (gnt !== 4'b1000) begin
            n_miss++;
            $display("FAIL off_grant: got %b expected 1000", gnt);
        end
        req = '0;
        step();
        n_vec++;
        if (gnt !== '0 || tbus[2:0] !== S_GATED) begin
            n_miss++;
            $display("FAIL off_release: gnt=%b state=%0d expected 0000/0", gnt, tbus[2:0]);
        end
        ptr = 3;
        for (int it = 0; it < 8; it++) begin
            m = NREQ'($urandom_range(1, 15));
            idx = rr_pick(m, ptr);
            e = 4'b0001 << idx;
            exp_q.push_back(e);
            req = m;
            for (int t = 0; t < 5 && gnt === '0; t++) step();
            n_vec++;
            if (gnt !== e) begin
                n_miss++;
                $display("FAIL off_rand%0d: req=%b got %b expected %b", it, m, gnt, e);
            end
            ptr = idx;
            repeat ($urandom_range(1, 3)) step();
            req = '0;
            repeat (2) step();
        end
        repeat (100) step();
        n_vec++;
        if (n_ungate != u0 || n_gate != g0) begin
            n_miss++;
            $display("FAIL off_no_pulses: ungates=%0d gates=%0d expected 0/0",
                     n_ungate - u0, n_gate - g0);
        end
    endtask

    task automatic test_async_reset();
        r_dcg_en = 1'b1;
        do_reset();
        req = 4'b0100;
        repeat (2) step();
        n_vec++;
        if (tbus[2:0] !== S_UNGATING || tbus[7:4] !== 4'd2) begin
            n_miss++;
            $display("FAIL arst_setup: state=%0d cnt=%0d expected 1/2", tbus[2:0], tbus[7:4]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (gnt !== '0 || dcg_ungate !== 1'b0 || dcg_gate !== 1'b0 || clk_active !== 1'b0 || tbus !== 8'h08) begin
            n_miss++;
            $display("FAIL arst_clear: gnt=%b ungate=%b gate=%b act=%b tbus=%h expected 0/0/0/0/08",
                     gnt, dcg_ungate, dcg_gate, clk_active, tbus);
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();
        n_vec++;
        if (tbus[2:0] !== S_GATED || dcg_ungate !== 1'b0) begin
            n_miss++;
            $display("FAIL arst_after: state=%0d ungate=%b expected 0/0", tbus[2:0], dcg_ungate);
        end
    endtask

    initial begin
        test_reset();
        test_wake();
        test_idle();
        test_back_to_back();
        test_idle_rearm();
        test_dcg_off();
        test_async_reset();
        repeat (2) step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d grants still expected, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
